// File: rtl/memory_filter_bank_if.sv
// Bundled load-stream, read and patch-write signals of the filter bank.
// Latency: none (wires only); the bank adds one cycle on reads.
// Backpressure: ld_ready from the bank throttles the load stream.
// master: stream source, read requester and patch writer.
// slave: the filter bank itself.
interface memory_filter_bank_if #(
  parameter int N_FILTERS = 4,
  parameter int K         = 3,
  parameter int DATA_W    = 8,
  parameter int BIAS_W    = 16,
  parameter int FILT_W    = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1,
  parameter int IDX_W     = $clog2(K*K+1)
);
  logic                     load_start;
  logic                     ld_valid;
  logic [BIAS_W-1:0]        ld_data;
  logic                     ld_ready;
  logic                     busy;
  logic                     load_done;
  logic                     rd_en;
  logic [FILT_W-1:0]        rd_filter;
  logic                     rd_valid;
  logic [K*K*DATA_W-1:0]    rd_weights;
  logic [BIAS_W-1:0]        rd_bias;
  logic                     wr_en;
  logic [FILT_W-1:0]        wr_filter;
  logic [IDX_W-1:0]         wr_index;
  logic [BIAS_W-1:0]        wr_data;

  modport master (
    output load_start, ld_valid, ld_data, rd_en, rd_filter,
           wr_en, wr_filter, wr_index, wr_data,
    input  ld_ready, busy, load_done, rd_valid, rd_weights, rd_bias
  );

  modport slave (
    input  load_start, ld_valid, ld_data, rd_en, rd_filter,
           wr_en, wr_filter, wr_index, wr_data,
    output ld_ready, busy, load_done, rd_valid, rd_weights, rd_bias
  );
endinterface

// File: rtl/memory_filter_bank.sv
// Register store of N_FILTERS signed KxK kernels plus biases for the CNN MAC array.
// Latency: reads return the full kernel and bias 1 cycle after rd_en.
// Backpressure: ld_ready high only in LOAD; stream words wait (no timeout) while ld_valid=0.
// Ports: clk, rstn (synchronous, active-high despite the name), bus (slave modport):
//   load_start/ld_valid/ld_data/ld_ready/busy/load_done - serial kernel load,
//   rd_en/rd_filter/rd_valid/rd_weights/rd_bias - parallel kernel read,
//   wr_en/wr_filter/wr_index/wr_data - single-element patch (index K*K = bias).
module memory_filter_bank #(
  parameter int N_FILTERS = 4,
  parameter int K         = 3,
  parameter int DATA_W    = 8,
  parameter int BIAS_W    = 16,
  parameter int FILT_W    = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1,
  parameter int IDX_W     = $clog2(K*K+1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  memory_filter_bank_if.slave  bus
);

  localparam int                KK     = K*K;
  localparam logic [IDX_W-1:0]  BIAS_E = IDX_W'(KK);
  localparam logic [FILT_W-1:0] LAST_F = FILT_W'(N_FILTERS-1);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         e_q, e_d;
  logic [FILT_W-1:0]        f_q, f_d;
  logic [DATA_W-1:0]        wgt_q [N_FILTERS][KK];
  logic [DATA_W-1:0]        wgt_d [N_FILTERS][KK];
  logic [BIAS_W-1:0]        bias_q [N_FILTERS];
  logic [BIAS_W-1:0]        bias_d [N_FILTERS];
  logic                     load_done_q, load_done_d;
  logic                     rd_valid_q, rd_valid_d;
  logic [KK*DATA_W-1:0]     rd_weights_q, rd_weights_d;
  logic [BIAS_W-1:0]        rd_bias_q, rd_bias_d;

  logic busy;
  logic ld_acc;
  logic wr_ok;
  logic rd_ok;

  assign busy   = (state_q == LOAD);
  assign ld_acc = busy & bus.ld_valid;
  // Patch writes and reads are locked out for the whole load.
  assign wr_ok  = bus.wr_en & ~busy;
  assign rd_ok  = bus.rd_en & ~busy;

  assign bus.ld_ready   = busy;
  assign bus.busy       = busy;
  assign bus.load_done  = load_done_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_weights = rd_weights_q;
  assign bus.rd_bias    = rd_bias_q;

  // Load FSM and element/filter counters.
  always_comb begin
    state_d     = state_q;
    e_d         = e_q;
    f_d         = f_q;
    load_done_d = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (bus.load_start) begin
          state_d = LOAD;
          e_d     = '0;
          f_d     = '0;
        end
      end
      LOAD: begin
        if (ld_acc) begin
          if (e_q == BIAS_E) begin
            e_d = '0;
            if (f_q == LAST_F) begin
              state_d     = READY;
              load_done_d = 1'b1;
            end else begin
              f_d = f_q + FILT_W'(1);
            end
          end else begin
            e_d = e_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage update. Out-of-range filter/index never match a loop slot and are
  // dropped. Reads below sample *_q, so a same-cycle write is seen next read.
  always_comb begin
    wgt_d  = wgt_q;
    bias_d = bias_q;
    for (int f = 0; f < N_FILTERS; f++) begin
      for (int e = 0; e < KK; e++) begin
        if (ld_acc && f_q == FILT_W'(f) && e_q == IDX_W'(e))
          wgt_d[f][e] = bus.ld_data[DATA_W-1:0];
        if (wr_ok && bus.wr_filter == FILT_W'(f) && bus.wr_index == IDX_W'(e))
          wgt_d[f][e] = bus.wr_data[DATA_W-1:0];
      end
      if (ld_acc && f_q == FILT_W'(f) && e_q == BIAS_E)
        bias_d[f] = bus.ld_data;
      if (wr_ok && bus.wr_filter == FILT_W'(f) && bus.wr_index == BIAS_E)
        bias_d[f] = bus.wr_data;
    end
  end

  // Read path: data registers hold when no read is issued; an out-of-range
  // filter matches nothing and returns zeros with rd_valid set.
  always_comb begin
    rd_valid_d   = rd_ok;
    rd_weights_d = rd_weights_q;
    rd_bias_d    = rd_bias_q;
    if (rd_ok) begin
      rd_weights_d = '0;
      rd_bias_d    = '0;
      for (int f = 0; f < N_FILTERS; f++) begin
        if (bus.rd_filter == FILT_W'(f)) begin
          for (int e = 0; e < KK; e++)
            rd_weights_d[e*DATA_W +: DATA_W] = wgt_q[f][e];
          rd_bias_d = bias_q[f];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q      <= IDLE;
      e_q          <= '0;
      f_q          <= '0;
      load_done_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_weights_q <= '0;
      rd_bias_q    <= '0;
      for (int f = 0; f < N_FILTERS; f++) begin
        bias_q[f] <= '0;
        for (int e = 0; e < KK; e++)
          wgt_q[f][e] <= '0;
      end
    end else begin
      state_q      <= state_d;
      e_q          <= e_d;
      f_q          <= f_d;
      load_done_q  <= load_done_d;
      rd_valid_q   <= rd_valid_d;
      rd_weights_q <= rd_weights_d;
      rd_bias_q    <= rd_bias_d;
      wgt_q        <= wgt_d;
      bias_q       <= bias_d;
    end
  end

endmodule
